// File: rtl/ysyx_25040101_ifu.sv
// Multi-cycle instruction fetch unit: REQ -> WAIT -> HOLD, one word per instruction.
// Optional fetch timeout fault enabled by defining YSYX_25040101_IFU_TIMEOUT_EN.
module ysyx_25040101_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [15:0] TIMEOUT  = 16'd255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rsp_valid_i,
   input  logic [31:0] mem_rsp_data_i,
   input  logic        mem_rsp_err_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   input  logic [31:0] next_pc_i,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_MISA = 2'd1;
   localparam logic [1:0] CAUSE_BUS  = 2'd2;
   localparam logic [1:0] CAUSE_TMO  = 2'd3;

   state_t      state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic [31:0] inst_r, inst_nxt_s;
   logic        fault_r, fault_nxt_s;
   logic [1:0]  cause_r, cause_nxt_s;
   logic        misaligned_s;

`ifdef YSYX_25040101_IFU_TIMEOUT_EN
   logic [15:0] tmo_cnt_r, tmo_cnt_nxt_s;
`else
   logic [15:0] unused_timeout_s;
   assign unused_timeout_s = TIMEOUT;
`endif

   assign misaligned_s = (pc_r[1:0] != 2'b00);

   // Output decode: only state and PC registers feed these, never an input.
   assign mem_req_valid_o = (state_r == ST_REQ) && !misaligned_s;
   assign inst_valid_o    = (state_r == ST_HOLD);
   assign mem_addr_o      = pc_r;
   assign pc_o            = pc_r;
   assign inst_o          = inst_r;
   assign fault_o         = fault_r;
   assign fault_cause_o   = cause_r;

   // Next-state and slot-capture logic.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      inst_nxt_s  = inst_r;
      fault_nxt_s = fault_r;
      cause_nxt_s = cause_r;
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
      tmo_cnt_nxt_s = tmo_cnt_r;
`endif
      case (state_r)
         ST_REQ: begin
            if (misaligned_s) begin
               state_nxt_s = ST_HOLD;
               inst_nxt_s  = 32'h0000_0000;
               fault_nxt_s = 1'b1;
               cause_nxt_s = CAUSE_MISA;
            end else if (mem_req_ready_i) begin
               state_nxt_s = ST_WAIT;
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
               tmo_cnt_nxt_s = 16'd0;
`endif
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid_i) begin
               state_nxt_s = ST_HOLD;
               if (mem_rsp_err_i) begin
                  inst_nxt_s  = 32'h0000_0000;
                  fault_nxt_s = 1'b1;
                  cause_nxt_s = CAUSE_BUS;
               end else begin
                  inst_nxt_s  = mem_rsp_data_i;
                  fault_nxt_s = 1'b0;
                  cause_nxt_s = CAUSE_NONE;
               end
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
            // The limit fires on the WAIT cycle whose increment would reach TIMEOUT.
            end else if (tmo_cnt_r == (TIMEOUT - 16'd1)) begin
               state_nxt_s = ST_HOLD;
               inst_nxt_s  = 32'h0000_0000;
               fault_nxt_s = 1'b1;
               cause_nxt_s = CAUSE_TMO;
            end else begin
               tmo_cnt_nxt_s = tmo_cnt_r + 16'd1;
            end
`else
            end else begin
               state_nxt_s = ST_WAIT;
            end
`endif
         end
         ST_HOLD: begin
            if (inst_ready_i) begin
               state_nxt_s = ST_REQ;
               pc_nxt_s    = next_pc_i;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_REQ;
         end
      endcase
   end

   // State and slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_REQ;
         pc_r    <= RESET_PC;
         inst_r  <= 32'h0000_0000;
         fault_r <= 1'b0;
         cause_r <= CAUSE_NONE;
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
         tmo_cnt_r <= 16'd0;
`endif
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         inst_r  <= inst_nxt_s;
         fault_r <= fault_nxt_s;
         cause_r <= cause_nxt_s;
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
         tmo_cnt_r <= tmo_cnt_nxt_s;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Self-checking bench for ysyx_25040101_ifu: directed slot table, reset corner cases,
// then random slots checked cycle by cycle against a slot-level reference model.
module tb_ysyx_25040101_ifu;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          TMO    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_addr_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        mem_rsp_err_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [31:0] next_pc_i;
   logic        fault_o;
   logic [1:0]  fault_cause_o;

   always #5 clk = ~clk;

   ysyx_25040101_ifu #(.RESET_PC(RST_PC), .TIMEOUT(16'd4)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
      .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
      .inst_o(inst_o), .pc_o(pc_o), .next_pc_i(next_pc_i),
      .fault_o(fault_o), .fault_cause_o(fault_cause_o)
   );

   typedef struct {
      int          a;        // cycles mem_req_ready_i stays low
      int          d;        // response delay in WAIT cycles
      int          h;        // cycles inst_ready_i stays low
      logic        err;
      logic [31:0] data;
      logic [31:0] nxt;
      logic [31:0] e_inst;
      logic        e_fault;
      logic [1:0]  e_cause;
   } vec_t;

   vec_t        tbl [8];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] cur_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (pc %h, t=%0t)", name, act, exp, cur_pc, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Number of WAIT cycles a fetch occupies given the memory response delay.
   function automatic int wait_len(input int d);
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
      return (d >= TMO) ? TMO : d + 1;
`else
      return d + 1;
`endif
   endfunction

   // Slot-level reference: what the core should see for a fetch at pc.
   task automatic model(input logic [31:0] pc, input int d, input logic err, input logic [31:0] data,
                        output logic [31:0] inst, output logic fault, output logic [1:0] cause);
      if (pc[1:0] != 2'b00) begin
         inst = 32'h0; fault = 1'b1; cause = 2'd1;
      end else if (wait_len(d) <= d) begin
         inst = 32'h0; fault = 1'b1; cause = 2'd3;
      end else if (err) begin
         inst = 32'h0; fault = 1'b1; cause = 2'd2;
      end else begin
         inst = data; fault = 1'b0; cause = 2'd0;
      end
   endtask

   // Drive one complete slot starting in REQ and check every cycle of it.
   task automatic run_slot(input vec_t v);
      int wl;
      wl = wait_len(v.d);
      if (cur_pc[1:0] != 2'b00) begin
         check("mis_req_valid", 32'(mem_req_valid_o), 32'd0);
         check("mis_addr", mem_addr_o, cur_pc);
         check("mis_inst_valid", 32'(inst_valid_o), 32'd0);
         mem_req_ready_i = rbit(); inst_ready_i = rbit(); mem_rsp_valid_i = 1'b0;
         step;
      end else begin
         for (int i = 0; i <= v.a; i++) begin
            check("req_valid", 32'(mem_req_valid_o), 32'd1);
            check("req_addr", mem_addr_o, cur_pc);
            check("req_inst_valid", 32'(inst_valid_o), 32'd0);
            mem_req_ready_i = (i == v.a); inst_ready_i = rbit();
            next_pc_i = $urandom; mem_rsp_valid_i = 1'b0;
            step;
         end
         for (int j = 0; j < wl; j++) begin
            check("wait_req_valid", 32'(mem_req_valid_o), 32'd0);
            check("wait_inst_valid", 32'(inst_valid_o), 32'd0);
            check("wait_addr", mem_addr_o, cur_pc);
            mem_req_ready_i = rbit(); inst_ready_i = rbit();
            mem_rsp_valid_i = (j == v.d);
            mem_rsp_data_i  = (j == v.d) ? v.data : $urandom;
            mem_rsp_err_i   = (j == v.d) ? v.err : rbit();
            step;
         end
      end
      for (int k = 0; k <= v.h; k++) begin
         check("hold_inst_valid", 32'(inst_valid_o), 32'd1);
         check("hold_req_valid", 32'(mem_req_valid_o), 32'd0);
         check("hold_inst", inst_o, v.e_inst);
         check("hold_pc", pc_o, cur_pc);
         check("hold_fault", 32'(fault_o), 32'(v.e_fault));
         check("hold_cause", 32'(fault_cause_o), 32'(v.e_cause));
         inst_ready_i = (k == v.h);
         next_pc_i = (k == v.h) ? v.nxt : $urandom;
         mem_rsp_valid_i = rbit(); mem_rsp_data_i = $urandom; mem_rsp_err_i = rbit();
         mem_req_ready_i = rbit();
         step;
      end
      inst_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0;
      cur_pc = v.nxt;
      check("next_pc_loaded", pc_o, cur_pc);
   endtask

   initial begin
      vec_t rv;
      tbl[0] = '{a:0, d:0, h:0, err:1'b0, data:32'h0000_0013, nxt:32'h8000_0004,
                 e_inst:32'h0000_0013, e_fault:1'b0, e_cause:2'd0};
      tbl[1] = '{a:4, d:3, h:2, err:1'b0, data:32'h0041_8193, nxt:32'h8000_0008,
                 e_inst:32'h0041_8193, e_fault:1'b0, e_cause:2'd0};
      tbl[2] = '{a:1, d:1, h:0, err:1'b1, data:32'hffff_ffff, nxt:32'h8000_1000,
                 e_inst:32'h0000_0000, e_fault:1'b1, e_cause:2'd2};
      tbl[3] = '{a:0, d:0, h:0, err:1'b0, data:32'h00a0_0093, nxt:32'h8000_0102,
                 e_inst:32'h00a0_0093, e_fault:1'b0, e_cause:2'd0};
      tbl[4] = '{a:0, d:0, h:1, err:1'b0, data:32'h1234_5678, nxt:32'h8000_0104,
                 e_inst:32'h0000_0000, e_fault:1'b1, e_cause:2'd1};
`ifdef YSYX_25040101_IFU_TIMEOUT_EN
      tbl[5] = '{a:0, d:4, h:0, err:1'b0, data:32'h0000_0073, nxt:32'h8000_0108,
                 e_inst:32'h0000_0000, e_fault:1'b1, e_cause:2'd3};
      tbl[7] = '{a:2, d:4, h:1, err:1'b1, data:32'h5555_aaaa, nxt:32'h8000_0110,
                 e_inst:32'h0000_0000, e_fault:1'b1, e_cause:2'd3};
`else
      tbl[5] = '{a:0, d:4, h:0, err:1'b0, data:32'h0000_0073, nxt:32'h8000_0108,
                 e_inst:32'h0000_0073, e_fault:1'b0, e_cause:2'd0};
      tbl[7] = '{a:2, d:4, h:1, err:1'b1, data:32'h5555_aaaa, nxt:32'h8000_0110,
                 e_inst:32'h0000_0000, e_fault:1'b1, e_cause:2'd2};
`endif
      tbl[6] = '{a:0, d:3, h:0, err:1'b0, data:32'h1111_1113, nxt:32'h8000_010c,
                 e_inst:32'h1111_1113, e_fault:1'b0, e_cause:2'd0};

      rst = 1'b1; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'h0;
      mem_rsp_err_i = 1'b0; inst_ready_i = 1'b0; next_pc_i = 32'h0;
      cur_pc = RST_PC;
      step; step;
      rst = 1'b0;
      check("rst_pc", pc_o, RST_PC);
      check("rst_req_valid", 32'(mem_req_valid_o), 32'd1);
      check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_fault", 32'(fault_o), 32'd0);
      check("rst_cause", 32'(fault_cause_o), 32'd0);

      for (int t = 0; t < 8; t++) run_slot(tbl[t]);

      // Reset while in WAIT, then a stale response the next cycle.
      mem_req_ready_i = 1'b1;
      step;
      mem_req_ready_i = 1'b0;
      check("pre_rst_wait_req_valid", 32'(mem_req_valid_o), 32'd0);
      rst = 1'b1;
      step;
      rst = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hdead_beef; mem_rsp_err_i = 1'b0;
      step;
      mem_rsp_valid_i = 1'b0;
      cur_pc = RST_PC;
      check("rstwait_pc", pc_o, RST_PC);
      check("rstwait_req_valid", 32'(mem_req_valid_o), 32'd1);
      check("rstwait_inst_valid", 32'(inst_valid_o), 32'd0);
      check("rstwait_inst", inst_o, 32'h0);
      run_slot('{a:0, d:0, h:0, err:1'b0, data:32'h0020_0113, nxt:32'h8000_0204,
                 e_inst:32'h0020_0113, e_fault:1'b0, e_cause:2'd0});

      // Reset while in HOLD with the core accepting: the handshake is discarded.
      mem_req_ready_i = 1'b1; step;
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0030_0193; step;
      mem_rsp_valid_i = 1'b0;
      check("pre_rst_hold_valid", 32'(inst_valid_o), 32'd1);
      rst = 1'b1; inst_ready_i = 1'b1; next_pc_i = 32'h0000_1234;
      step;
      rst = 1'b0; inst_ready_i = 1'b0;
      cur_pc = RST_PC;
      check("rsthold_pc", pc_o, RST_PC);
      check("rsthold_inst_valid", 32'(inst_valid_o), 32'd0);
      check("rsthold_fault", 32'(fault_o), 32'd0);

      for (int n = 0; n < 200; n++) begin
         rv.a = $urandom_range(0, 3);
         rv.d = $urandom_range(0, 5);
         rv.h = $urandom_range(0, 3);
         rv.err = ($urandom_range(0, 4) == 0);
         rv.data = $urandom;
         rv.nxt = {$urandom_range(0, 65535), 14'($urandom_range(0, 16383)), 2'b00};
         if ($urandom_range(0, 5) == 0) rv.nxt[1:0] = 2'($urandom_range(1, 3));
         model(cur_pc, rv.d, rv.err, rv.data, rv.e_inst, rv.e_fault, rv.e_cause);
         run_slot(rv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
